// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared constants and helpers for the dff_pipe register pipeline
//
// Contents:
//   DFF_DEFAULT_WIDTH  data width used by the traffic-signal datapath
//   DFF_DEFAULT_DEPTH  stage count used by the traffic-signal datapath
//   occ_width(depth)   bits needed to count 0..depth occupied stages
package dff_pkg;

    localparam int DFF_DEFAULT_WIDTH = 8;
    localparam int DFF_DEFAULT_DEPTH = 2;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// rtl/dff_stage.sv - one WIDTH-bit pipeline register with its valid bit
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   en       in   load enable
//   clr      in   synchronous clear, wins over en
//   d        in   WIDTH  data in
//   d_valid  in   qualifies d
//   q        out  WIDTH  registered data
//   q_valid  out  registered valid
module dff_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = d;
            valid_d = d_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - parametrised multi-stage register pipeline with valid tracking and occupancy
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   en       in   pipeline advances only when 1
//   clr      in   synchronous clear, wins over en
//   d        in   WIDTH  data into stage 0
//   d_valid  in   qualifies d
//   q        out  WIDTH  last-stage data
//   qbar     out  WIDTH  ~q
//   q_valid  out  last-stage valid
//   occ      out  occ_width(DEPTH)  stages currently holding valid data
//   rise     out  WIDTH  per-bit rising edge of q (0 unless DFF_PIPE_EDGE_DET_EN)
//   fall     out  WIDTH  per-bit falling edge of q (0 unless DFF_PIPE_EDGE_DET_EN)
//
// Build option: define DFF_PIPE_EDGE_DET_EN to build the q history register
// and drive rise/fall.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter int               DEPTH     = DFF_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         clr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qbar,
    output logic                         q_valid,
    output logic [occ_width(DEPTH)-1:0]  occ,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall
);

    localparam int OW = occ_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]            stage_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        logic             stage_vin;

        if (i == 0) begin : g_first
            assign stage_in  = d;
            assign stage_vin = d_valid;
        end else begin : g_next
            assign stage_in  = stage_data[i-1];
            assign stage_vin = stage_valid[i-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .clr     (clr),
            .d       (stage_in),
            .d_valid (stage_vin),
            .q       (stage_data[i]),
            .q_valid (stage_valid[i])
        );
    end

    // Occupancy is tracked incrementally rather than by popcount: one entry
    // in, one out per enabled edge. When full, the outgoing slot is valid, so
    // a valid input cannot push the count past DEPTH.
    logic [OW-1:0] occ_d;
    logic [OW-1:0] occ_q;

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OW'(d_valid) - OW'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign q       = stage_data[DEPTH-1];
    assign qbar    = ~stage_data[DEPTH-1];
    assign q_valid = stage_valid[DEPTH-1];
    assign occ     = occ_q;

`ifdef DFF_PIPE_EDGE_DET_EN
    // History of q sampled on every edge, ignoring en, so a pulse lasts
    // exactly one cycle even while the pipeline is stalled.
    logic [WIDTH-1:0] hist_d;
    logic [WIDTH-1:0] hist_q;

    always_comb begin
        hist_d = q;
        if (clr) begin
            hist_d = RESET_VAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= RESET_VAL;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise = q & ~hist_q;
    assign fall = ~q & hist_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - scoreboard bench for dff_pipe (WIDTH=8, DEPTH=3)
module tb_dff_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 3;
    localparam logic [7:0] RV    = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_valid;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       q_valid;
    logic [1:0] occ;
    logic [7:0] rise;
    logic [7:0] fall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .qbar    (qbar),
        .q_valid (q_valid),
        .occ     (occ),
        .rise    (rise),
        .fall    (fall)
    );

    typedef struct packed {
        logic [7:0] q;
        logic       qv;
        logic [1:0] occ;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the pipe is a fixed-length list of slots, newest first.
    logic [7:0] m_data[$];
    logic       m_valid[$];
    logic [7:0] m_prev;

    task automatic model_reset();
        m_data.delete();
        m_valid.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_data.push_back(RV);
            m_valid.push_back(1'b0);
        end
        m_prev = RV;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   n;
        n = 0;
        foreach (m_valid[i]) if (m_valid[i]) n++;
        e.q   = m_data[DEPTH-1];
        e.qv  = m_valid[DEPTH-1];
        e.occ = 2'(n);
`ifdef DFF_PIPE_EDGE_DET_EN
        e.rise = e.q & ~m_prev;
        e.fall = ~e.q & m_prev;
`else
        e.rise = 8'h00;
        e.fall = 8'h00;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("q",       q,              e.q);
        check("qbar",    qbar,           ~e.q);
        check("q_valid", {7'd0, q_valid}, {7'd0, e.qv});
        check("occ",     {6'd0, occ},    {6'd0, e.occ});
        check("rise",    rise,           e.rise);
        check("fall",    fall,           e.fall);
    endtask

    // Monitor: one expectation per clocked step, compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_all(e);
        end
    end

    // Drive one edge worth of inputs, advance the model, and wait until the
    // monitor has consumed the result.
    task automatic step(input logic s_en, input logic s_clr, input logic [7:0] s_d, input logic s_dv);
        en      = s_en;
        clr     = s_clr;
        d       = s_d;
        d_valid = s_dv;
        if (s_clr) begin
            model_reset();
        end else begin
            m_prev = m_data[DEPTH-1];
            if (s_en) begin
                m_data.push_front(s_d);
                m_valid.push_front(s_dv);
                void'(m_data.pop_back());
                void'(m_valid.pop_back());
            end
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        d       = 8'h00;
        d_valid = 1'b0;
        model_reset();
        #3;
        check_all(model_out());
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Fill in order, then keep streaming.
        step(1, 0, 8'hA1, 1);
        step(1, 0, 8'hB2, 1);
        step(1, 0, 8'hC3, 1);
        step(1, 0, 8'h00, 0);

        // Stall on the second edge.
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'hA1, 1);
        step(0, 0, 8'hEE, 1);
        step(1, 0, 8'hB2, 1);
        step(1, 0, 8'hC3, 1);

        // Full pipe then clr with en on the same edge.
        step(1, 0, 8'h11, 1);
        step(1, 1, 8'h77, 1);
        step(1, 0, 8'h22, 0);

        // Bubble pattern.
        step(1, 0, 8'h31, 1);
        step(1, 0, 8'h32, 0);
        step(1, 0, 8'h33, 1);
        step(1, 0, 8'h34, 1);
        step(1, 0, 8'h35, 1);
        step(1, 0, 8'h36, 1);
        step(1, 0, 8'h37, 1);

        // Edge detector stream: q goes 00 -> 0F -> 03.
        step(1, 1, 8'h00, 0);
        step(1, 0, 8'h0F, 1);
        step(1, 0, 8'h03, 1);
        step(1, 0, 8'h03, 1);
        step(1, 0, 8'h03, 1);
        step(1, 0, 8'h03, 1);
        step(0, 0, 8'h03, 1);

        // Asynchronous reset between edges with the pipe full of A5.
        step(1, 0, 8'hA5, 1);
        step(1, 0, 8'hA5, 1);
        step(1, 0, 8'hA5, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(model_out());
        @(negedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 8'h5A, 1);
        step(1, 0, 8'h5A, 0);
        step(1, 0, 8'h5B, 1);
        step(1, 0, 8'h5C, 1);
        step(1, 0, 8'h5D, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 8'($urandom()),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
